// File: rtl/risc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc_pkg : shared operation and state encodings for the core     |
// | rev 1.1                                                          |
// +------------------------------------------------------------------+
package risc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } alu_op_t;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SRL    = 5'd3,
    OP_SRA    = 5'd4,
    OP_OR     = 5'd5,
    OP_AND    = 5'd6,
    OP_XOR    = 5'd7,
    OP_SLTU   = 5'd8,
    OP_SLT    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } exec_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } exec_state_t;

  function automatic logic is_div_op(input exec_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_iter : unsigned restoring divider, one quotient bit per clk   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_active;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;

  // Dividend bits shift out of r_quo into the partial remainder while
  // quotient bits shift in from the bottom.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign done      = r_active && (r_count == '0);
  assign quotient  = r_quo;
  assign remainder = r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else if (start) begin
      r_count  <= CNT_W'(XLEN);
      r_active <= 1'b1;
      r_quo    <= dividend;
      r_rem    <= '0;
      r_dvs    <= divisor;
    end else if (r_active && (r_count != '0)) begin
      r_rem   <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      r_quo   <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
      r_count <= r_count - CNT_W'(1);
    end else if (done) begin
      r_active <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_unit : RV32I ALU + M-extension execute stage, valid/ready    |
// | rev 2.0                                                          |
// +------------------------------------------------------------------+
module exec_unit
  import risc_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  exec_op_t        op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  exec_state_t       r_state;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_want_rem;

  logic              w_accept;
  logic              w_signed_div;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_long_div;
  logic              w_div_done;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]   w_fast;
  logic [XLEN-1:0]   w_div_a;
  logic [XLEN-1:0]   w_div_b;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_div_result;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = (r_state == ST_DIV) && !w_div_done;

  assign w_signed_div = (op == OP_DIV) || (op == OP_REM);
  assign w_b_zero     = (b == '0);
  assign w_ovf        = w_signed_div && (a == c_int_min) && (b == '1);
  assign w_long_div   = is_div_op(op) && !w_b_zero && !w_ovf;
  assign w_div_a      = (w_signed_div && a[XLEN-1]) ? -a : a;
  assign w_div_b      = (w_signed_div && b[XLEN-1]) ? -b : b;
  assign w_shamt      = b[SHAMT_W-1:0];

  // Operands are extended to 2*XLEN so one modular product serves every
  // signedness combination.
  assign w_mul_a = {{XLEN{a[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU))}}, a};
  assign w_mul_b = {{XLEN{b[XLEN-1] && (op == OP_MULH)}}, b};
  assign w_prod  = w_mul_a * w_mul_b;

  always_comb begin
    w_fast = '0;
    case (op)
      OP_ADD:    w_fast = a + b;
      OP_SUB:    w_fast = a - b;
      OP_SLL:    w_fast = a << w_shamt;
      OP_SRL:    w_fast = a >> w_shamt;
      OP_SRA:    w_fast = $signed(a) >>> w_shamt;
      OP_OR:     w_fast = a | b;
      OP_AND:    w_fast = a & b;
      OP_XOR:    w_fast = a ^ b;
      OP_SLTU:   w_fast = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLT:    w_fast = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL:    w_fast = w_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  w_fast = w_prod[2*XLEN-1:XLEN];
      // Only the divide-by-zero and signed-overflow cases resolve here.
      OP_DIV,
      OP_DIVU:   w_fast = w_b_zero ? '1 : a;
      OP_REM,
      OP_REMU:   w_fast = w_b_zero ? a : '0;
      default:   w_fast = '0;
    endcase
  end

  assign w_div_result = r_want_rem ? (r_neg_r ? -w_rem : w_rem)
                                   : (r_neg_q ? -w_quo : w_quo);

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_accept && w_long_div),
    .flush     (flush),
    .dividend  (w_div_a),
    .divisor   (w_div_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_want_rem  <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_DIV: begin
          if (w_div_done) begin
            r_result    <= w_div_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_IDLE, ST_HOLD: begin
          if ((r_state == ST_HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          if (w_accept) begin
            r_neg_q    <= w_signed_div && (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_r    <= w_signed_div && a[XLEN-1];
            r_want_rem <= (op == OP_REM) || (op == OP_REMU);
            if (w_long_div) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_DIV;
            end else begin
              r_result    <= w_fast;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Parametrised execute unit; next generation of the combinational ALU.
- XLEN-wide; covers RV32I ALU ops plus the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits between decode/issue and writeback with valid/ready handshakes on both sides.
- Single-cycle registered result for ALU and multiply ops; iterative multi-cycle divide.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from b (derived; do not override).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of accepted/in-flight op
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept this cycle
- op  input  exec_op_t  operation select
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2/imm)
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- busy  output  1  high while a divide iterates

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 after release.
- FSM states:
  - IDLE: waiting for an op.
  - DIV: divider iterating.
  - HOLD: result valid, waiting for out_ready.
- Handshake rules:
  - Accept occurs on an edge with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready); supports back-to-back ops at one per cycle.
  - Output transfer on an edge with out_valid && out_ready.
  - result and out_valid are stable while out_valid && !out_ready.
- Single-cycle ops (all ALU ops, all MUL*, divide special cases):
  - Accept at edge k gives out_valid=1 from edge k+1.
  - Next state is HOLD.
- Normal divide ops:
  - Accept at edge k gives state=DIV and busy=1.
  - XLEN restoring iterations on edges k+1..k+XLEN, one quotient bit per edge.
  - out_valid=1 from edge k+XLEN+1, then HOLD with busy=0.
- ALU semantics:
  - ADD/SUB: modulo 2^XLEN.
  - SLL/SRL/SRA: shift by b[SHAMT_W-1:0]; SRA sign-fills.
  - SLT: signed compare; SLTU: unsigned compare; result is 1 or 0 zero-extended.
  - AND/OR/XOR: bitwise.
- Multiply semantics: full 2*XLEN product.
  - MUL returns the low half.
  - MULH: signed x signed, high half.
  - MULHSU: signed a x unsigned b, high half.
  - MULHU: unsigned x unsigned, high half.
- Divide semantics:
  - Signed ops divide magnitudes, then fix sign: quotient negative iff signs differ; remainder takes the dividend's sign.
  - Divide by zero (single-cycle): DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed overflow, a = -2^(XLEN-1) and b = -1 (single-cycle): DIV result = a; REM result = 0.
- Boundary conditions:
  - Sampling: op/a/b are sampled only on accept; later changes are ignored.
  - flush: has priority over everything. On the next edge: state=IDLE, out_valid=0, busy=0, divider cleared.
  - Same-cycle flush and in_valid: the op is not accepted.
  - flush in HOLD: the pending result is discarded.
  - in_valid during DIV: in_ready=0; the op is stalled, not dropped.
  - HOLD with out_ready=1 and a new accept on the same edge: the new result replaces the old one (single-cycle op) or the FSM enters DIV with out_valid=0.
  - rst_n asserted mid-divide: immediate return to reset values; no partial result is emitted.
  - Undefined op encoding: result 0, single-cycle.

Decomposition:
- risc_pkg:
  - Add exec_op_t, a 5-bit enum: ADD, SUB, SLL, SRL, SRA, OR, AND, XOR, SLTU, SLT, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Add the exec_state_t enum (IDLE, DIV, HOLD).
  - Existing alu_op_t is unchanged.
- One sub-module: div_iter (XLEN parameter).
  - Inputs: start, flush, unsigned dividend, unsigned divisor.
  - Outputs: quotient, remainder, done after XLEN cycles.
  - Sign pre/post-processing and special cases stay in exec_unit.

Test Plan (XLEN=32):
- Single-cycle ALU ops:
  - SRA, a=0x8000_0010, b=0x24: result 0xF800_0001 one edge after accept.
  - SLT, a=0xFFFF_FFFF, b=1: result 1.
  - SLTU, same operands: result 0.
- Multiply ops:
  - MULH, a=b=0x8000_0000: result 0x4000_0000.
  - MULHSU, a=0xFFFF_FFFF, b=2: result 0xFFFF_FFFF.
  - MUL, a=0xFFFF_FFFF, b=2: result 0xFFFF_FFFE.
- Signed divide:
  - DIV, a=-7, b=2: result 0xFFFF_FFFD; out_valid exactly 33 edges after accept; busy high 32 cycles; in_ready=0 throughout.
  - REM, same operands: result 0xFFFF_FFFF.
- Divide special cases:
  - DIVU, b=0: result 0xFFFF_FFFF.
  - REM, a=5, b=0: result 5.
  - DIV, a=0x8000_0000, b=0xFFFF_FFFF: result 0x8000_0000.
  - All three complete in 1 cycle.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles: result and out_valid stable.
  - Then out_ready=1 with an ADD offered on the same edge: the ADD result follows on the next edge with no bubble.
- flush and reset mid-operation:
  - flush at iteration 10 of a DIVU: out_valid never asserts; the next ADD is accepted the edge after flush.
  - rst_n pulsed low mid-divide: outputs 0 immediately (async).
